pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and fetches 32-bit instruction words over a req/ack handshake.
- Presents opcode/function fields to the decoder, then computes the next PC from the decoder's br_type/pc_sel outputs, the latched ALU flags and the register-file rs value.
- Also supplies the link value (PC+4) for call instructions.

---
 rtl/pc_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : PC register and instruction-fetch stage feeding the control
//            decoder; computes next PC from decoder selects, flags and rs.
//            Define BRANCH_STATS_EN to add instr_cnt / taken_cnt counters.
// Revision : 1.0
// ============================================================================
module pc_fetch_unit #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [5:0]      opcode,
  output logic [5:0]      function_val,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic [2:0]      br_type,
  input  logic [1:0]      pc_sel,
  input  logic            flag_we,
  input  logic            alu_zero,
  input  logic            alu_carry,
  input  logic            alu_ovf,
  input  logic [PC_W-1:0] rs_val,
  output logic [PC_W-1:0] link_pc,
  output logic [PC_W-1:0] pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     taken_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t          state, state_next;
  logic            zf, cf, vf;
  logic            z_eff, c_eff, v_eff;
  logic            is_branch_op, cond_met;
  logic [PC_W-1:0] p4, br_off, next_pc;
  logic            unused_rs_low;

  assign unused_rs_low = &{1'b0, rs_val[1:0]};

  assign imem_addr    = pc;
  assign opcode       = instr[31:26];
  assign function_val = instr[5:0];
  assign p4           = pc + PC_W'(4);
  assign link_pc      = p4;
  assign br_off       = {{(PC_W-18){instr[15]}}, instr[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Request is masked during reset so an abandoned fetch never reaches memory.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = !rst;
        if (imem_ack) state_next = EXEC;
      end
      EXEC: begin
        if (exec_done) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // A flag write in the same cycle as exec_done is seen by the branch.
  assign z_eff = flag_we ? alu_zero  : zf;
  assign c_eff = flag_we ? alu_carry : cf;
  assign v_eff = flag_we ? alu_ovf   : vf;

  always_comb begin
    is_branch_op = 1'b0;
    case (opcode)
      6'b000001, 6'b000100, 6'b000101, 6'b001111, 6'b010000: is_branch_op = 1'b1;
      default: is_branch_op = 1'b0;
    endcase
  end

  always_comb begin
    cond_met = 1'b0;
    if (is_branch_op) begin
      case (br_type)
        3'b000:  cond_met = 1'b1;
        3'b001:  cond_met = z_eff;
        3'b010:  cond_met = !z_eff;
        3'b011:  cond_met = c_eff;
        3'b100:  cond_met = v_eff;
        default: cond_met = 1'b0;
      endcase
    end
  end

  always_comb begin
    next_pc = p4;
    case (pc_sel)
      2'b01:   next_pc = {p4[PC_W-1:28], instr[25:0], 2'b00};
      2'b10:   next_pc = {rs_val[PC_W-1:2], 2'b00};
      2'b00:   if (cond_met) next_pc = p4 + br_off;
      default: next_pc = p4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_VEC;
      instr       <= '0;
      instr_valid <= 1'b0;
      zf          <= 1'b0;
      cf          <= 1'b0;
      vf          <= 1'b0;
    end else begin
      if (flag_we) begin
        zf <= alu_zero;
        cf <= alu_carry;
        vf <= alu_ovf;
      end
      if (state == FETCH && imem_ack) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (state == EXEC && exec_done) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt <= '0;
      taken_cnt <= '0;
    end else if (state == EXEC && exec_done) begin
      if (instr_cnt != '1) instr_cnt <= instr_cnt + 32'd1;
      if (next_pc != p4 && taken_cnt != '1) taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Self-checking bench for pc_fetch_unit (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  opcode, function_val;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [2:0]  br_type;
  logic [1:0]  pc_sel;
  logic        flag_we, alu_zero, alu_carry, alu_ovf;
  logic [31:0] rs_val, link_pc, pc;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [31:0] instr_cnt;
`endif

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_W(32), .RESET_VEC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .opcode(opcode), .function_val(function_val), .instr(instr), .instr_valid(instr_valid),
    .exec_done(exec_done), .br_type(br_type), .pc_sel(pc_sel), .flag_we(flag_we),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .rs_val(rs_val), .link_pc(link_pc), .pc(pc)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .instr_cnt(instr_cnt)
`endif
  );

  typedef struct {
    logic [31:0] start;
    logic        pz, pcy, pv;
    logic [31:0] rdata;
    logic [2:0]  bt;
    logic [1:0]  sel;
    logic [31:0] rs;
    logic        fwe, wz, wc, wv;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] sb_q[$];
  logic [31:0] mpc;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Holds FETCH for `waits` cycles, then acks; returns at the first EXEC negedge.
  task automatic fetch(input string nm, input logic [31:0] rdata, input int waits);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk({nm, "_req"}, 32'(imem_req), 32'd1);
      chk({nm, "_addr"}, imem_addr, mpc);
      if (i == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = rdata;
      end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(instr_valid), 32'd1);
    chk({nm, "_instr"}, instr, rdata);
    chk({nm, "_opcode"}, 32'(opcode), 32'(rdata[31:26]));
    chk({nm, "_func"}, 32'(function_val), 32'(rdata[5:0]));
    chk({nm, "_reqlow"}, 32'(imem_req), 32'd0);
    chk({nm, "_link"}, link_pc, mpc + 32'd4);
  endtask

  task automatic execute(input string nm, input int stall, input logic [2:0] bt,
                         input logic [1:0] sel, input logic [31:0] rs, input logic fwe,
                         input logic z, input logic c, input logic v, input logic [31:0] exp);
    logic [31:0] e;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({nm, "_stallpc"}, pc, mpc);
      chk({nm, "_stallvalid"}, 32'(instr_valid), 32'd1);
    end
    br_type = bt; pc_sel = sel; rs_val = rs;
    flag_we = fwe; alu_zero = z; alu_carry = c; alu_ovf = v;
    exec_done = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    exec_done = 1'b0; flag_we = 1'b0;
    e = sb_q.pop_front();
    chk({nm, "_pc"}, pc, e);
    chk({nm, "_done_valid"}, 32'(instr_valid), 32'd0);
    mpc = e;
  endtask

  task automatic run(input string nm, input logic [31:0] rdata, input int waits, input int stall,
                     input logic [2:0] bt, input logic [1:0] sel, input logic [31:0] rs,
                     input logic fwe, input logic z, input logic c, input logic v,
                     input logic [31:0] exp);
    fetch(nm, rdata, waits);
    execute(nm, stall, bt, sel, rs, fwe, z, c, v, exp);
  endtask

  initial begin
    // start, pz,pc,pv, rdata, bt, sel, rs, fwe,wz,wc,wv, expected next pc
    vecs[0]  = '{32'h0000_0100, 1'b1,1'b0,1'b0, 32'h1000_FFFE, 3'b001, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_00FC};
    vecs[1]  = '{32'h0000_0100, 1'b0,1'b0,1'b0, 32'h1000_FFFE, 3'b001, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0104};
    vecs[2]  = '{32'h1000_0040, 1'b0,1'b0,1'b0, 32'h0800_0010, 3'b000, 2'b01, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h1000_0040};
    vecs[3]  = '{32'h0000_0040, 1'b0,1'b0,1'b0, 32'h0000_0000, 3'b000, 2'b10, 32'h0000_2003, 1'b0,1'b0,1'b0,1'b0, 32'h0000_2000};
    vecs[4]  = '{32'h0000_0200, 1'b0,1'b0,1'b0, 32'h1400_0003, 3'b011, 2'b00, 32'h0, 1'b1,1'b0,1'b1,1'b0, 32'h0000_0210};
    vecs[5]  = '{32'hFFFF_FFFC, 1'b0,1'b0,1'b0, 32'h0000_0000, 3'b000, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0000};
    vecs[6]  = '{32'h0000_0300, 1'b1,1'b0,1'b0, 32'h0400_0010, 3'b010, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0304};
    vecs[7]  = '{32'h0000_0400, 1'b0,1'b0,1'b1, 32'h3C00_0004, 3'b100, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0414};
    vecs[8]  = '{32'h0000_0500, 1'b1,1'b1,1'b1, 32'h4000_0004, 3'b101, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0504};
    vecs[9]  = '{32'h0000_0600, 1'b0,1'b0,1'b0, 32'h1000_0004, 3'b000, 2'b11, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0604};
    vecs[10] = '{32'h0000_0000, 1'b0,1'b0,1'b0, 32'h1000_FFF0, 3'b000, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hFFFF_FFC4};
    vecs[11] = '{32'h0000_0700, 1'b0,1'b0,1'b0, 32'h1000_0001, 3'b000, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0708};
    vecs[12] = '{32'h0000_0800, 1'b0,1'b0,1'b0, 32'h0C00_0005, 3'b000, 2'b00, 32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0000_0804};

    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; exec_done = 1'b0;
    br_type = '0; pc_sel = '0; flag_we = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    alu_ovf = 1'b0; rs_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0;
    mpc = 32'h0;

    run("first", 32'h0000_0020, 3, 0, 3'b000, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4);

    for (int i = 0; i < 13; i++) begin
      run($sformatf("v%0d_setup", i), 32'h0, 0, 0, 3'b000, 2'b10, vecs[i].start,
          1'b1, vecs[i].pz, vecs[i].pcy, vecs[i].pv, vecs[i].start);
      run($sformatf("v%0d", i), vecs[i].rdata, i % 3, i % 2, vecs[i].bt, vecs[i].sel,
          vecs[i].rs, vecs[i].fwe, vecs[i].wz, vecs[i].wc, vecs[i].wv, vecs[i].exp);
    end

    // Reset in FETCH while memory acks: the word must be dropped.
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    mpc = 32'h0;

    run("s0", 32'h0,         1, 0, 3'b000, 2'b00, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
    run("s1", 32'h0,         0, 1, 3'b000, 2'b10, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    run("s2", 32'h0,         2, 0, 3'b000, 2'b00, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h104);
    run("s3", 32'h0800_0000, 0, 0, 3'b000, 2'b01, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    run("s4", 32'h0,         0, 0, 3'b000, 2'b00, 32'h0,   1'b0, 1'b0, 1'b0, 1'b0, 32'h4);
`ifdef BRANCH_STATS_EN
    chk("instr_cnt", instr_cnt, 32'd5);
    chk("taken_cnt", 32'(taken_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
